// File: rtl/ycc_block_sequencer.sv
// rtl/ycc_block_sequencer.sv - RGB to YCrCb block sequencer for one 8x8 JPEG block
//
// Purpose:
//   Accepts PIX_COUNT RGB pixels, converts each through one registered stage,
//   stores Y/Cr/Cb planes in an internal buffer, then drains the block
//   component-planar (Y, then Cr, then Cb) to the zig-zag/DCT stage.
//   Single-buffered: input stalls while a block drains.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   abort      in   synchronous; discards the current block, back to FILL
//   in_r/g/b   in   8-bit RGB sample
//   in_valid   in   pixel offered
//   in_ready   out  pixel accepted this cycle when in_valid
//   out_data   out  converted sample
//   out_comp   out  0=Y, 1=Cr, 2=Cb
//   out_index  out  raster index of the sample within the block
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts
//   out_last   out  final sample of each component
//   block_done out  one-cycle pulse after the final sample of a block transfers
module ycc_block_sequencer #(
  parameter int PIX_COUNT = 64,
  parameter bit CHROMA_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       abort,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic [1:0] out_comp,
  output logic [5:0] out_index,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       block_done
);

  localparam logic [2:0] S_FILL     = 3'd0;
  localparam logic [2:0] S_WAIT     = 3'd1;
  localparam logic [2:0] S_DRAIN_Y  = 3'd2;
  localparam logic [2:0] S_DRAIN_CR = 3'd3;
  localparam logic [2:0] S_DRAIN_CB = 3'd4;

  localparam logic [5:0] LAST_IDX = 6'(PIX_COUNT - 1);

  logic [2:0] r_state;
  logic [5:0] r_acc_cnt;   // pixels accepted so far in this block
  logic [5:0] r_wr_cnt;    // buffer write pointer, lags r_acc_cnt by the pipeline
  logic [5:0] r_rd_cnt;
  logic       r_pipe_valid;
  logic [7:0] r_pipe_y;
  logic [7:0] r_pipe_cr;
  logic [7:0] r_pipe_cb;
  logic       r_block_done;

  logic [7:0] r_buf_y  [0:PIX_COUNT-1];
  logic [7:0] r_buf_cr [0:PIX_COUNT-1];
  logic [7:0] r_buf_cb [0:PIX_COUNT-1];

  logic        w_in_ready;
  logic        w_accept;
  logic        w_drain;
  logic        w_xfer;
  logic        w_rd_last;
  logic [7:0]  w_rd_data;
  logic [1:0]  w_comp;

  logic signed [17:0] w_r_s;
  logic signed [17:0] w_g_s;
  logic signed [17:0] w_b_s;
  logic signed [17:0] w_y_sum;
  logic signed [17:0] w_cr_sum;
  logic signed [17:0] w_cb_sum;
  logic [7:0]         w_y;
  logic [7:0]         w_cr;
  logic [7:0]         w_cb;

  // Gated by reset so the port reads 0 while reset is held even though the
  // state register already sits at FILL.
  assign w_in_ready = (r_state == S_FILL) && !reset;
  assign w_accept   = in_valid && w_in_ready;
  assign w_drain    = (r_state == S_DRAIN_Y) || (r_state == S_DRAIN_CR) ||
                      (r_state == S_DRAIN_CB);
  assign w_xfer     = w_drain && out_ready;
  assign w_rd_last  = (r_rd_cnt == LAST_IDX);

  // Conversion: zero-extended samples, signed 18-bit sums, floor shift.
  assign w_r_s    = $signed({10'd0, in_r});
  assign w_g_s    = $signed({10'd0, in_g});
  assign w_b_s    = $signed({10'd0, in_b});
  assign w_y_sum  = 18'sd77 * w_r_s + 18'sd150 * w_g_s + 18'sd29 * w_b_s;
  assign w_cr_sum = 18'sd128 * w_r_s - 18'sd107 * w_g_s - 18'sd21 * w_b_s;
  assign w_cb_sum = 18'sd128 * w_b_s - 18'sd43 * w_r_s - 18'sd85 * w_g_s;
  assign w_y      = 8'(w_y_sum >>> 8);
  assign w_cr     = 8'(w_cr_sum >>> 8) + 8'd128;
  assign w_cb     = 8'(w_cb_sum >>> 8) + 8'd128;

  always_comb begin
    w_rd_data = 8'd0;
    w_comp    = 2'd0;
    case (r_state)
      S_DRAIN_Y:  w_rd_data = r_buf_y[r_rd_cnt];
      S_DRAIN_CR: begin
        w_rd_data = r_buf_cr[r_rd_cnt];
        w_comp    = 2'd1;
      end
      S_DRAIN_CB: begin
        w_rd_data = r_buf_cb[r_rd_cnt];
        w_comp    = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FILL;
      r_acc_cnt    <= 6'd0;
      r_wr_cnt     <= 6'd0;
      r_rd_cnt     <= 6'd0;
      r_pipe_valid <= 1'b0;
      r_pipe_y     <= 8'd0;
      r_pipe_cr    <= 8'd0;
      r_pipe_cb    <= 8'd0;
      r_block_done <= 1'b0;
    end else if (abort) begin
      // Abort wins over accept, pipeline write and drain transfer alike.
      r_state      <= S_FILL;
      r_acc_cnt    <= 6'd0;
      r_wr_cnt     <= 6'd0;
      r_rd_cnt     <= 6'd0;
      r_pipe_valid <= 1'b0;
      r_block_done <= 1'b0;
    end else begin
      r_block_done <= 1'b0;
      r_pipe_valid <= w_accept;
      if (w_accept) begin
        r_pipe_y  <= w_y;
        r_pipe_cr <= w_cr;
        r_pipe_cb <= w_cb;
        r_acc_cnt <= (r_acc_cnt == LAST_IDX) ? 6'd0 : r_acc_cnt + 6'd1;
      end
      if (r_pipe_valid) begin
        r_wr_cnt <= (r_wr_cnt == LAST_IDX) ? 6'd0 : r_wr_cnt + 6'd1;
      end
      if (w_xfer) begin
        r_rd_cnt <= w_rd_last ? 6'd0 : r_rd_cnt + 6'd1;
      end
      case (r_state)
        S_FILL: begin
          if (w_accept && (r_acc_cnt == LAST_IDX)) r_state <= S_WAIT;
        end
        // One idle cycle so the final pixel leaves the pipeline register.
        S_WAIT: r_state <= S_DRAIN_Y;
        S_DRAIN_Y: begin
          if (w_xfer && w_rd_last) begin
            if (CHROMA_EN) begin
              r_state <= S_DRAIN_CR;
            end else begin
              r_state      <= S_FILL;
              r_block_done <= 1'b1;
            end
          end
        end
        S_DRAIN_CR: begin
          if (w_xfer && w_rd_last) r_state <= S_DRAIN_CB;
        end
        S_DRAIN_CB: begin
          if (w_xfer && w_rd_last) begin
            r_state      <= S_FILL;
            r_block_done <= 1'b1;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  // Buffer contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (r_pipe_valid && !abort) begin
      r_buf_y[r_wr_cnt]  <= r_pipe_y;
      r_buf_cr[r_wr_cnt] <= r_pipe_cr;
      r_buf_cb[r_wr_cnt] <= r_pipe_cb;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_drain;
  assign out_data   = w_rd_data;
  assign out_comp   = w_comp;
  assign out_index  = w_drain ? r_rd_cnt : 6'd0;
  assign out_last   = w_drain && w_rd_last;
  assign block_done = r_block_done;

endmodule
